mem_master: RTL and testbench
=============================

Name: mem_master

Overview:
- Initiator side of the word-addressed, byte-masked RAM interface.
- Accepts load/store requests from the CPU pipeline via a valid/ready handshake.
- Drives registered address, byte write mask and lane-aligned write data to the RAM, then captures, realigns and sign/zero-extends read data.
- Returns one response per request and reports illegal, out-of-range or misaligned accesses as faults.

Parameters:
- MEM_WORDS, 2048: number of 32-bit words behind the RAM; byte addresses at or beyond MEM_WORDS*4 fault.

Ports:
- clk  in  1  clock; RAM samples on negedge.
- reset_n  in  1  asynchronous reset, active low.
- req_valid_in  in  1  request valid.
- req_ready_out  out  1  high only in IDLE.
- req_write_in  in  1  1 = store, 0 = load.
- req_width_in  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned_in  in  1  load zero-extends when 1, sign-extends when 0.
- req_address_in  in  32  byte address.
- req_write_value_in  in  32  store data, right-justified.
- resp_valid_out  out  1  one-cycle response strobe.
- resp_read_value_out  out  32  extended load data; 0 for stores and faults.
- resp_fault_out  out  1  qualified by resp_valid_out.
- mem_address_out  out  32  word-aligned byte address to RAM; bits [1:0] always 0.
- mem_write_mask_out  out  4  byte-lane write enables.
- mem_write_value_out  out  32  lane-aligned store data.
- mem_read_value_in  in  32  RAM read data.

Behaviour:
- Reset (async, reset_n=0): state IDLE; req_ready_out 1; resp_valid_out 0; resp_read_value_out 0; resp_fault_out 0; all mem_* outputs 0.
  - Mask clears immediately, so the next negedge never writes.
- States and transitions: IDLE -> FIRST -> [SECOND] -> RESP -> IDLE.
- IDLE, accept when req_valid_in && req_ready_out:
  - Latch the request and compute off = addr[1:0].
  - Byte-mask base: 0001 (byte), 0011 (half), 1111 (word).
  - m64 = base << off (8 bits); d64 = {32'b0, data} << (8*off).
  - Fault if any of: width==11; addr >= MEM_WORDS*4; m64[7:4]!=0 with feature off; m64[7:4]!=0 and addr+4 beyond range.
  - On fault: go to RESP; mem outputs stay 0.
  - Otherwise: go to FIRST; register mem_address_out={addr[31:2],2'b00}, mask=m64[3:0], value=d64[31:0].
- FIRST:
  - RAM performs the write at this cycle's negedge and presents read data by the next posedge.
  - At that posedge, capture mem_read_value_in into lo.
  - If m64[7:4]!=0: go to SECOND with address+4, mask=m64[7:4], value=d64[63:32].
  - Otherwise: go to RESP with mask cleared to 0.
- SECOND: capture hi at the posedge, clear mask, go to RESP.
- RESP:
  - resp_valid_out=1 for exactly one cycle.
  - Load: r = ({hi,lo} >> 8*off) masked to width, then sign- or zero-extended.
  - Store: r = 0.
  - Then return to IDLE.
- Latency:
  - Accept at edge N; resp_valid_out high in the cycle after edge N+1 (fault), N+2 (single access) or N+3 (split).
  - Next accept no earlier than the edge ending the RESP cycle's following IDLE cycle.
- mem_write_mask_out is 0 in every state except FIRST/SECOND of a store; loads always drive mask 0.
- Request inputs are ignored outside IDLE; they need not be held after acceptance.
- Reset mid-operation aborts the access; no response is produced. A store whose negedge has already passed stays written.

Optional Feature:
- MEM_MASTER_MISALIGNED_SPLIT_EN:
  - Defined: a misaligned half or word access crossing a word boundary is split into FIRST+SECOND as above.
  - Undefined: any misaligned half/word faults with no RAM access; SECOND state is not built.
  - Aligned-access behaviour and timing are identical either way.

Test Plan:
- Word store 0xDEADBEEF @0x10 -> FIRST shows addr 0x10, mask 1111, value 0xDEADBEEF; word load @0x10 -> resp 0xDEADBEEF, fault 0, two cycles after accept.
- Byte store 0xA5 @0x13 -> mask 1000, value lanes [31:24]=0xA5; signed byte load @0x13 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
- Word 0x80017FFF @0x10: signed half load @0x12 -> 0xFFFF8001; unsigned half @0x10 -> 0x00007FFF.
- Split enabled, word store 0x11223344 @0x21:
  - FIRST: addr 0x20, mask 1110, value 0x22334400.
  - SECOND: addr 0x24, mask 0001, value 0x00000011.
  - Word load @0x21 -> 0x11223344.
- Split disabled, same store -> resp_fault 1, mask stays 0000, memory unchanged; width 11 or addr 0x2000 (MEM_WORDS=2048) -> fault, no access.
- Assert reset_n low during FIRST of a store, before the negedge -> mask 0 immediately, no write, no response; after release req_ready_out 1.

Source files
------------

// File: rtl/mem_master_if.sv
// rtl/mem_master_if.sv - request/response and RAM signal bundle for mem_master
// master modport is the initiator (mem_master) side; slave is the CPU/RAM side.
interface mem_master_if;
  logic        req_valid_in;
  logic        req_ready_out;
  logic        req_write_in;
  logic [1:0]  req_width_in;
  logic        req_unsigned_in;
  logic [31:0] req_address_in;
  logic [31:0] req_write_value_in;
  logic        resp_valid_out;
  logic [31:0] resp_read_value_out;
  logic        resp_fault_out;
  logic [31:0] mem_address_out;
  logic [3:0]  mem_write_mask_out;
  logic [31:0] mem_write_value_out;
  logic [31:0] mem_read_value_in;

  modport master (
    input  req_valid_in, req_write_in, req_width_in, req_unsigned_in,
           req_address_in, req_write_value_in, mem_read_value_in,
    output req_ready_out, resp_valid_out, resp_read_value_out, resp_fault_out,
           mem_address_out, mem_write_mask_out, mem_write_value_out
  );

  modport slave (
    output req_valid_in, req_write_in, req_width_in, req_unsigned_in,
           req_address_in, req_write_value_in, mem_read_value_in,
    input  req_ready_out, resp_valid_out, resp_read_value_out, resp_fault_out,
           mem_address_out, mem_write_mask_out, mem_write_value_out
  );
endinterface

// File: rtl/mem_master.sv
// rtl/mem_master.sv - load/store initiator for a word-addressed, byte-masked RAM
// Define MEM_MASTER_MISALIGNED_SPLIT_EN to split word-crossing accesses into two RAM cycles.
module mem_master #(
  parameter int unsigned MEM_WORDS = 2048
) (
  input logic          clk,
  input logic          reset_n,
  mem_master_if.master bus
);
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
    SECOND,
`endif
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  base;
  logic [7:0]  m64;
  logic [31:0] d_lo;
  logic        crosses, cross_fault, fault_req;

  logic        write_q, unsigned_q, fault_q;
  logic [1:0]  width_q, off_q;
  logic [31:0] lo_q;
  logic [31:0] mem_address_q, mem_value_q;
  logic [3:0]  mem_mask_q;
  logic [63:0] pair;
  logic [31:0] aligned, ext;

`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
  logic [63:0] d64;
  logic [31:0] d_hi, d_hi_q, hi_q;
  logic [3:0]  m_hi_q;
  logic        split_q;
`endif

  always_comb begin
    base = 4'b0000;
    case (bus.req_width_in)
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      2'b10:   base = 4'b1111;
      default: base = 4'b0000;
    endcase
    m64     = {4'b0000, base} << bus.req_address_in[1:0];
    crosses = |m64[7:4];
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
    d64  = {32'b0, bus.req_write_value_in} << {bus.req_address_in[1:0], 3'b000};
    d_lo = d64[31:0];
    d_hi = d64[63:32];
    // the second word of a split must itself be inside the RAM
    cross_fault = crosses &&
                  (({1'b0, bus.req_address_in[31:2], 2'b00} + 33'd4) >= ADDR_LIMIT);
`else
    d_lo        = bus.req_write_value_in << {bus.req_address_in[1:0], 3'b000};
    cross_fault = crosses;
`endif
    fault_req = (bus.req_width_in == 2'b11) ||
                ({1'b0, bus.req_address_in} >= ADDR_LIMIT) || cross_fault;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid_in) state_nxt = fault_req ? RESP : FIRST;
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
      FIRST:  state_nxt = split_q ? SECOND : RESP;
      SECOND: state_nxt = RESP;
`else
      FIRST:  state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q       <= 1'b0;
      unsigned_q    <= 1'b0;
      fault_q       <= 1'b0;
      width_q       <= 2'b00;
      off_q         <= 2'b00;
      lo_q          <= 32'b0;
      mem_address_q <= 32'b0;
      mem_mask_q    <= 4'b0;
      mem_value_q   <= 32'b0;
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
      hi_q          <= 32'b0;
      d_hi_q        <= 32'b0;
      m_hi_q        <= 4'b0;
      split_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.req_valid_in) begin
          write_q    <= bus.req_write_in;
          unsigned_q <= bus.req_unsigned_in;
          width_q    <= bus.req_width_in;
          off_q      <= bus.req_address_in[1:0];
          fault_q    <= fault_req;
          lo_q       <= 32'b0;
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
          hi_q    <= 32'b0;
          split_q <= crosses;
          m_hi_q  <= bus.req_write_in ? m64[7:4] : 4'b0;
          d_hi_q  <= bus.req_write_in ? d_hi : 32'b0;
`endif
          if (!fault_req) begin
            mem_address_q <= {bus.req_address_in[31:2], 2'b00};
            mem_mask_q    <= bus.req_write_in ? m64[3:0] : 4'b0;
            mem_value_q   <= bus.req_write_in ? d_lo : 32'b0;
          end
        end
        FIRST: begin
          lo_q <= bus.mem_read_value_in;
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
          if (split_q) begin
            mem_address_q <= mem_address_q + 32'd4;
            mem_mask_q    <= m_hi_q;
            mem_value_q   <= d_hi_q;
          end else begin
            mem_mask_q <= 4'b0;
          end
        end
        SECOND: begin
          hi_q       <= bus.mem_read_value_in;
          mem_mask_q <= 4'b0;
`else
          mem_mask_q <= 4'b0;
`endif
        end
        RESP: begin
          mem_address_q <= 32'b0;
          mem_mask_q    <= 4'b0;
          mem_value_q   <= 32'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
    pair = {hi_q, lo_q};
`else
    pair = {32'b0, lo_q};
`endif
    aligned = pair[{1'b0, off_q, 3'b000} +: 32];
    case (width_q)
      2'b00:   ext = unsigned_q ? {24'b0, aligned[7:0]} : {{24{aligned[7]}}, aligned[7:0]};
      2'b01:   ext = unsigned_q ? {16'b0, aligned[15:0]} : {{16{aligned[15]}}, aligned[15:0]};
      default: ext = aligned;
    endcase
  end

  assign bus.req_ready_out       = (state == IDLE);
  assign bus.resp_valid_out      = (state == RESP);
  assign bus.resp_fault_out      = (state == RESP) && fault_q;
  assign bus.resp_read_value_out = ((state == RESP) && !write_q && !fault_q) ? ext : 32'b0;
  assign bus.mem_address_out     = mem_address_q;
  assign bus.mem_write_mask_out  = mem_mask_q;
  assign bus.mem_write_value_out = mem_value_q;
endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - directed self-checking bench for mem_master
// Expectations follow MEM_MASTER_MISALIGNED_SPLIT_EN when the bench is built with it.
module tb_mem_master;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] ram [0:2047];

  mem_master_if bus();
  mem_master #(.MEM_WORDS(2048)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // RAM model: writes and reads on the falling edge
  always @(negedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.mem_write_mask_out[b])
        ram[bus.mem_address_out[12:2]][8*b +: 8] = bus.mem_write_value_out[8*b +: 8];
    bus.mem_read_value_in = ram[bus.mem_address_out[12:2]];
  end

  int          lat;
  logic [31:0] r_val;
  logic        r_fault, after_valid, s1_ready, saw;
  logic [31:0] s1_addr, s1_val, s2_addr, s2_val;
  logic [3:0]  s1_mask, s2_mask, max_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] w, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1;
    bus.req_write_in = wr;
    bus.req_width_in = w;
    bus.req_unsigned_in = uns;
    bus.req_address_in = a;
    bus.req_write_value_in = d;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    bus.req_address_in = 32'hFFFF_FFFF;
    bus.req_write_value_in = 32'hFFFF_FFFF;
    bus.req_width_in = 2'b11;
    lat = -1; r_val = 32'hx; r_fault = 1'bx; after_valid = 1'bx; max_mask = 4'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) begin
        s1_addr = bus.mem_address_out; s1_mask = bus.mem_write_mask_out;
        s1_val = bus.mem_write_value_out; s1_ready = bus.req_ready_out;
      end
      if (k == 2) begin
        s2_addr = bus.mem_address_out; s2_mask = bus.mem_write_mask_out;
        s2_val = bus.mem_write_value_out;
      end
      max_mask = max_mask | bus.mem_write_mask_out;
      if (lat >= 0) begin
        after_valid = bus.resp_valid_out;
        break;
      end
      if (bus.resp_valid_out) begin
        lat = k; r_val = bus.resp_read_value_out; r_fault = bus.resp_fault_out;
      end
    end
  endtask

  initial begin
    bus.req_valid_in = 1'b0;
    bus.req_write_in = 1'b0;
    bus.req_width_in = 2'b00;
    bus.req_unsigned_in = 1'b0;
    bus.req_address_in = 32'b0;
    bus.req_write_value_in = 32'b0;
    for (int i = 0; i < 2048; i++) ram[i] = 32'b0;
    #2;
    chk("rst_ready", 32'(bus.req_ready_out), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid_out), 32'd0);
    chk("rst_resp_value", bus.resp_read_value_out, 32'd0);
    chk("rst_fault", 32'(bus.resp_fault_out), 32'd0);
    chk("rst_mem_addr", bus.mem_address_out, 32'd0);
    chk("rst_mem_mask", 32'(bus.mem_write_mask_out), 32'd0);
    chk("rst_mem_value", bus.mem_write_value_out, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_first_addr", s1_addr, 32'h10);
    chk("sw_first_mask", 32'(s1_mask), 32'hF);
    chk("sw_first_value", s1_val, 32'hDEADBEEF);
    chk("sw_busy_ready", 32'(s1_ready), 32'd0);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_resp_value", r_val, 32'd0);
    chk("sw_pulse_one", 32'(after_valid), 32'd0);

    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_value", r_val, 32'hDEADBEEF);
    chk("lw_fault", 32'(r_fault), 32'd0);
    chk("lw_lat", 32'(lat), 32'd2);
    chk("lw_no_mask", 32'(max_mask), 32'd0);

    issue(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    chk("sb_mask", 32'(s1_mask), 32'h8);
    chk("sb_value", s1_val, 32'hA5000000);
    chk("sb_ram", ram[4], 32'hA5ADBEEF);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb_signed", r_val, 32'hFFFFFFA5);
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lbu_unsigned", r_val, 32'h000000A5);

    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80017FFF);
    issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh_signed", r_val, 32'hFFFF8001);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("lhu_unsigned", r_val, 32'h00007FFF);

    issue(1'b1, 2'b10, 1'b0, 32'h21, 32'h11223344);
`ifdef MEM_MASTER_MISALIGNED_SPLIT_EN
    chk("split_first_addr", s1_addr, 32'h20);
    chk("split_first_mask", 32'(s1_mask), 32'hE);
    chk("split_first_value", s1_val, 32'h22334400);
    chk("split_second_addr", s2_addr, 32'h24);
    chk("split_second_mask", 32'(s2_mask), 32'h1);
    chk("split_second_value", s2_val, 32'h00000011);
    chk("split_store_lat", 32'(lat), 32'd3);
    issue(1'b0, 2'b10, 1'b0, 32'h21, 32'h0);
    chk("split_load_value", r_val, 32'h11223344);
    chk("split_load_lat", 32'(lat), 32'd3);
`else
    chk("nosplit_fault", 32'(r_fault), 32'd1);
    chk("nosplit_lat", 32'(lat), 32'd1);
    chk("nosplit_no_mask", 32'(max_mask), 32'd0);
    chk("nosplit_ram_lo", ram[8], 32'd0);
    chk("nosplit_ram_hi", ram[9], 32'd0);
`endif

    issue(1'b1, 2'b10, 1'b0, 32'h1FFD, 32'h55555555);
    chk("edge_split_fault", 32'(r_fault), 32'd1);
    chk("edge_split_no_mask", 32'(max_mask), 32'd0);

    issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678);
    chk("width11_fault", 32'(r_fault), 32'd1);
    chk("width11_lat", 32'(lat), 32'd1);
    chk("width11_no_mask", 32'(max_mask), 32'd0);
    chk("width11_addr", s1_addr, 32'd0);

    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678);
    chk("range_fault", 32'(r_fault), 32'd1);
    chk("range_no_mask", 32'(max_mask), 32'd0);
    chk("range_value", r_val, 32'd0);

    issue(1'b1, 2'b10, 1'b0, 32'h1FFC, 32'h12345678);
    chk("last_word_fault", 32'(r_fault), 32'd0);
    chk("last_word_ram", ram[2047], 32'h12345678);
    chk("ram_unchanged", ram[4], 32'h80017FFF);

    // abort a store while in FIRST, before its falling edge
    @(posedge clk); #1;
    bus.req_valid_in = 1'b1;
    bus.req_write_in = 1'b1;
    bus.req_width_in = 2'b10;
    bus.req_address_in = 32'h30;
    bus.req_write_value_in = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req_valid_in = 1'b0;
    chk("abort_first_mask", 32'(bus.mem_write_mask_out), 32'hF);
    reset_n = 1'b0;
    #1;
    chk("abort_mask_cleared", 32'(bus.mem_write_mask_out), 32'd0);
    @(negedge clk); #1;
    chk("abort_no_write", ram[12], 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw = saw | bus.resp_valid_out;
    end
    chk("abort_no_resp", 32'(saw), 32'd0);
    chk("abort_ready", 32'(bus.req_ready_out), 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    chk("abort_readback", r_val, 32'd0);
    chk("abort_readback_lat", 32'(lat), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
